// File: rtl/mux_pkg.sv
// mux_pkg: FSM state type and a width helper shared by the stream mux blocks
package mux_pkg;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// rr_pick_n: combinational rotate-priority finder, first request after ptr wins
module rr_pick_n
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    // Scan from the farthest slot inward so the nearest request after ptr overwrites
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = N_CH; i >= 1; i--)
            if (req[(int'(ptr) + i) % N_CH]) begin
                gnt_idx = SEL_W'((int'(ptr) + i) % N_CH);
                gnt_vld = 1'b1;
            end
    end

endmodule

// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N-channel valid/ready stream mux with fixed/round-robin select and packet locking
module mux_nto1_stream
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 8,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [N_CH*W-1:0]   d_in,
    input  logic [N_CH-1:0]     valid_in,
    input  logic [N_CH-1:0]     last_in,
    output logic [N_CH-1:0]     ready_out,
    input  logic [SEL_W-1:0]    sel_in,
    input  logic                rr_en_in,
    output logic [W-1:0]        y_out,
    output logic                last_out,
    output logic [SEL_W-1:0]    ch_out,
    output logic                valid_out,
    input  logic                ready_in
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_vld;
    logic [SEL_W-1:0] cand;
    logic             cand_vld;
    logic             load;
    logic             xfer;

    rr_pick_n #(.N_CH(N_CH)) u_pick (
        .req     (valid_in),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    // A locked packet owns the mux regardless of sel_in/rr_en_in until its last beat
    always_comb begin
        load      = !valid_out || ready_in;
        cand      = (state == ST_LOCKED) ? lock_ch : rr_en_in ? pick_idx : sel_in;
        cand_vld  = (state == ST_LOCKED) ? 1'b1 : rr_en_in ? pick_vld : (int'(sel_in) < N_CH);
        ready_out = (load && cand_vld) ? N_CH'(1) << cand : '0;
        xfer      = |(ready_out & valid_in);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            ptr       <= SEL_W'(N_CH - 1);
            lock_ch   <= '0;
            valid_out <= 1'b0;
            y_out     <= '0;
            last_out  <= 1'b0;
            ch_out    <= '0;
        end else if (xfer) begin
            valid_out <= 1'b1;
            y_out     <= d_in[int'(cand)*W +: W];
            last_out  <= last_in[cand];
            ch_out    <= cand;
            if (state == ST_IDLE && rr_en_in)
                ptr <= cand;
            if (state == ST_IDLE && !last_in[cand]) begin
                state   <= ST_LOCKED;
                lock_ch <= cand;
            end else if (state == ST_LOCKED && last_in[cand])
                state <= ST_IDLE;
        end else if (ready_in)
            valid_out <= 1'b0;
    end

endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb_mux_nto1_stream: directed vector table plus hand-written backpressure and lock/reset sequences
module tb_mux_nto1_stream;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] d_in;
    logic [3:0]  valid_in;
    logic [3:0]  last_in;
    logic [3:0]  ready_out;
    logic [1:0]  sel_in;
    logic        rr_en_in;
    logic [7:0]  y_out;
    logic        last_out;
    logic [1:0]  ch_out;
    logic        valid_out;
    logic        ready_in;

    int checks = 0;
    int passed = 0;

    always #5 clk_in = ~clk_in;

    mux_nto1_stream #(.N_CH(4), .W(8)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .d_in      (d_in),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .ready_out (ready_out),
        .sel_in    (sel_in),
        .rr_en_in  (rr_en_in),
        .y_out     (y_out),
        .last_out  (last_out),
        .ch_out    (ch_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    typedef struct {
        logic        rst;
        logic        rr;
        logic [1:0]  sel;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        rdy;
        logic        chk_r;
        logic [3:0]  er;
        logic        evo;
        logic [7:0]  ey;
        logic        el;
        logic [1:0]  ech;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        else
            passed++;
    endtask

    task automatic drive(input logic r, input logic rr, input logic [1:0] s, input logic [3:0] v,
                         input logic [3:0] l, input logic [31:0] d, input logic rdy);
        rst_in = r; rr_en_in = rr; sel_in = s; valid_in = v; last_in = l; d_in = d; ready_in = rdy;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    logic [7:0] cur, nxt;
    logic       p_fire, c_fire;
    int         got_n;

    initial begin
        // rst rr sel v l d rdy chk_r | ready valid y last ch
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11, 1'b1, 2'd0};
        tbl[3]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 4'h2, 1'b1, 8'h22, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 4'h4, 1'b1, 8'h33, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 4'h8, 1'b1, 8'h44, 1'b1, 2'd3};
        tbl[6]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11, 1'b1, 2'd0};
        tbl[7]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 4'h2, 1'b1, 8'h22, 1'b1, 2'd1};
        tbl[8]  = '{1'b0, 1'b0, 2'd2, 4'h4, 4'h4, 32'h00A50000, 1'b1, 1'b1, 4'h4, 1'b1, 8'hA5, 1'b1, 2'd2};
        tbl[9]  = '{1'b0, 1'b0, 2'd3, 4'h0, 4'h0, 32'h00000000, 1'b1, 1'b1, 4'h8, 1'b0, 8'hA5, 1'b1, 2'd2};
        tbl[10] = '{1'b0, 1'b1, 2'd0, 4'h2, 4'h0, 32'h00001100, 1'b1, 1'b1, 4'h2, 1'b1, 8'h11, 1'b0, 2'd1};
        tbl[11] = '{1'b0, 1'b1, 2'd0, 4'h7, 4'h0, 32'h00C012A0, 1'b1, 1'b1, 4'h2, 1'b1, 8'h12, 1'b0, 2'd1};
        tbl[12] = '{1'b0, 1'b1, 2'd0, 4'h7, 4'h2, 32'h00C013A0, 1'b1, 1'b1, 4'h2, 1'b1, 8'h13, 1'b1, 2'd1};
        tbl[13] = '{1'b0, 1'b1, 2'd0, 4'h5, 4'h5, 32'h00C000A0, 1'b1, 1'b1, 4'h4, 1'b1, 8'hC0, 1'b1, 2'd2};
        tbl[14] = '{1'b0, 1'b1, 2'd0, 4'h1, 4'h1, 32'h000000A0, 1'b1, 1'b1, 4'h1, 1'b1, 8'hA0, 1'b1, 2'd0};
        tbl[15] = '{1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 32'h00000000, 1'b1, 1'b1, 4'h0, 1'b0, 8'hA0, 1'b1, 2'd0};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].rr, tbl[i].sel, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].rdy);
            #1;
            if (tbl[i].chk_r)
                chk($sformatf("row%0d ready_out", i), 32'(ready_out), 32'(tbl[i].er));
            tick();
            chk($sformatf("row%0d valid_out", i), 32'(valid_out), 32'(tbl[i].evo));
            chk($sformatf("row%0d y_out", i), 32'(y_out), 32'(tbl[i].ey));
            chk($sformatf("row%0d last_out", i), 32'(last_out), 32'(tbl[i].el));
            chk($sformatf("row%0d ch_out", i), 32'(ch_out), 32'(tbl[i].ech));
        end

        // Backpressure: fixed ch0 single-beat stream 0x42..0x49, consumer stalls 3 cycles after first beat
        cur = 8'h42;
        nxt = 8'h42;
        got_n = 0;
        for (int c = 0; c < 40 && got_n < 8; c++) begin
            drive(1'b0, 1'b0, 2'd0, {3'b000, cur != 8'h4A}, 4'h1, {24'h0, cur}, !(c >= 1 && c <= 3));
            #1;
            if (c >= 1 && c <= 3) begin
                chk($sformatf("stall%0d y_out", c), 32'(y_out), 32'h42);
                chk($sformatf("stall%0d ready_out", c), 32'(ready_out), 32'h0);
                chk($sformatf("stall%0d valid_out", c), 32'(valid_out), 32'h1);
            end
            p_fire = ready_out[0] && valid_in[0];
            c_fire = valid_out && ready_in;
            if (c_fire) begin
                chk($sformatf("stream beat%0d", got_n), 32'(y_out), 32'(nxt));
                nxt = nxt + 8'h1;
                got_n++;
            end
            if (p_fire)
                cur = cur + 8'h1;
            tick();
        end
        chk("stream beat count", 32'(got_n), 32'd8);

        // Lock override: sel_in moves 1->3 mid-packet, ch1 keeps the grant
        drive(1'b0, 1'b0, 2'd1, 4'h2, 4'h0, 32'h00006100, 1'b1);
        #1;
        chk("lock first ready_out", 32'(ready_out), 32'h2);
        tick();
        chk("lock first y_out", 32'(y_out), 32'h61);
        drive(1'b0, 1'b0, 2'd3, 4'hA, 4'h8, 32'h3F006200, 1'b1);
        #1;
        chk("lock override ready_out", 32'(ready_out), 32'h2);
        tick();
        chk("lock override y_out", 32'(y_out), 32'h62);
        chk("lock override ch_out", 32'(ch_out), 32'h1);
        drive(1'b1, 1'b0, 2'd3, 4'hA, 4'h8, 32'h3F006300, 1'b1);
        tick();
        chk("midpkt reset valid_out", 32'(valid_out), 32'h0);
        chk("midpkt reset y_out", 32'(y_out), 32'h0);
        drive(1'b0, 1'b0, 2'd3, 4'hA, 4'hA, 32'h3F006300, 1'b1);
        #1;
        chk("post reset ready_out", 32'(ready_out), 32'h8);
        tick();
        chk("post reset y_out", 32'(y_out), 32'h3F);
        chk("post reset ch_out", 32'(ch_out), 32'h3);
        chk("post reset last_out", 32'(last_out), 32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
